// File: rtl/div_seq_pkg.sv
// Shared defines for the iterative divider: FSM encodings, handshake levels and reset/zero constants.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        RstEnable         = 1'b1;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;
    localparam int          DivIterNum        = 32;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DivIterNum
) (
    input  logic [WIDTH-1:0] partial_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] partial_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // partial_i < divisor_i always holds, so a set top bit of the shifted
    // value already guarantees the subtract fits; otherwise diff[WIDTH] is the borrow.
    always_comb begin
        shifted   = {partial_i, dvd_bit_i};
        diff      = shifted - {1'b0, divisor_i};
        q_bit_o   = shifted[WIDTH] | ~diff[WIDTH];
        partial_o = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// DIV/DIVU sequencer beside EX: 32 restoring iterations, result = {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: |dividend| < |divisor| finishes through the short BYZERO path.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DivIterNum,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg_a;
    logic             neg_b;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_partial;
    logic             step_q;
    logic [WIDTH-1:0] quo, quo_fix, rem_fix;
    logic             early;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_i (partial),
        .dvd_bit_i (dvd[WIDTH-1]),
        .divisor_i (dvs),
        .partial_o (step_partial),
        .q_bit_o   (step_q)
    );

    // Magnitude of the most negative value wraps to itself and is used as unsigned.
    always_comb begin
        mag_a   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag_b   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_OUT_EN
        early   = (mag_a < mag_b);
`else
        early   = 1'b0;
`endif
        quo     = {dvd[WIDTH-2:0], step_q};
        quo_fix = (neg_a ^ neg_b) ? -quo : quo;
        rem_fix = neg_a ? -step_partial : step_partial;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state    <= DivFree;
            cnt      <= '0;
            partial  <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            busy_o   <= 1'b0;
        end else if (annul_i && state != DivFree) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        busy_o  <= 1'b1;
                        cnt     <= '0;
                        partial <= '0;
                        dvs     <= mag_b;
                        neg_a   <= signed_div_i & opdata1_i[WIDTH-1];
                        neg_b   <= signed_div_i & opdata2_i[WIDTH-1];
                        // dvd carries the finished remainder on the short path
                        if (opdata2_i == WIDTH'(ZeroWord)) begin
                            state <= DivByZero;
                            dvd   <= '0;
                        end else if (early) begin
                            state <= DivByZero;
                            dvd   <= opdata1_i;
                        end else begin
                            state <= DivOn;
                            dvd   <= mag_a;
                        end
                    end
                end
                DivByZero: begin
                    state    <= DivEnd;
                    result_o <= {dvd, {WIDTH{1'b0}}};
                    ready_o  <= DivResultReady;
                end
                DivOn: begin
                    partial <= step_partial;
                    dvd     <= quo;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state    <= DivEnd;
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state    <= DivFree;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                        busy_o   <= 1'b0;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table through a result/latency scoreboard plus corner sequences.
module tb_div_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           busy_o;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
    } vec_t;

    vec_t           vecs[11];
    logic [2*W-1:0] sb_res[$];
    int             sb_lat[$];
    int             pass_cnt  = 0;
    int             total_cnt = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] mag(input logic s, input logic [W-1:0] x);
        return (s && x[W-1]) ? (~x + 1) : x;
    endfunction

    // Edges after the accept edge until ready_o is seen.
    function automatic int exp_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mag(s, a) < mag(s, b)) return 1;
`endif
        return 32;
    endfunction

    // Truncating division reference built on the language's unsigned / and %.
    function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        if (b == 0) return '0;
        q = mag(s, a) / mag(s, b);
        r = mag(s, a) % mag(s, b);
        if (s && (a[W-1] ^ b[W-1])) q = ~q + 1;
        if (s && a[W-1]) r = ~r + 1;
        return {r, q};
    endfunction

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_res, input int hold, input bit scramble);
        int             n;
        bit             seen, busy_ok;
        logic [2*W-1:0] er;
        int             el;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb_res.push_back(exp_res);
        sb_lat.push_back(exp_lat(s, a, b));
        n = 0; seen = 0; busy_ok = 1;
        while (n < 40 && !seen) begin
            tick();
            n++;
            if (!busy_o) busy_ok = 0;
            if (scramble) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
            seen = ready_o;
        end
        er = sb_res.pop_front();
        el = sb_lat.pop_front();
        check("ready_seen", 64'(seen), 64'd1);
        check("latency", 64'(n - 1), 64'(el));
        check("result", result_o, er);
        check("busy_during_op", 64'(busy_ok), 64'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_result", result_o, er);
            check("hold_ready", 64'(ready_o), 64'd1);
        end
        start_i = 1'b0;
        tick();
        check("idle_flags", {62'd0, ready_o, busy_o}, 64'd0);
        check("idle_result", result_o, 64'd0);
    endtask

    initial begin
        bit rose;
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}};
        vecs[3]  = '{1'b1, 32'd5,          32'd0,          {32'h0000_0000, 32'h0000_0000}};
        vecs[4]  = '{1'b0, 32'd5,          32'd9,          {32'h0000_0005, 32'h0000_0000}};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0000_0000, 32'hFFFF_FFFF}};
        vecs[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'h0000_0003}};
        vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0000_0000}};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFE,  32'd5,          {32'hFFFF_FFFE, 32'h0000_0000}};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h0000_0001}};

        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        tick(); tick();
        check("reset_result", result_o, 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res, (i == 0) ? 5 : 1, i == 1);

        // Abort after 10 iterations, then restart immediately.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        rose = 0;
        for (int k = 0; k < 11; k++) begin
            tick();
            if (ready_o) rose = 1;
        end
        annul_i = 1'b1;
        tick();
        check("abort_no_ready", 64'(rose), 64'd0);
        check("abort_flags", {62'd0, ready_o, busy_o}, 64'd0);
        check("abort_result", result_o, 64'd0);
        annul_i = 1'b0;
        run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1, 1'b0);

        // annul held in IDLE blocks acceptance.
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        tick(); tick();
        check("annul_idle_busy", 64'(busy_o), 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        tick();

        // annul in END.
        signed_div_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        tick(); tick();
        check("end_ready", 64'(ready_o), 64'd1);
        annul_i = 1'b1;
        tick();
        check("annul_end_flags", {62'd0, ready_o, busy_o}, 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        tick();

        // Reset in the middle of an operation.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        for (int k = 0; k < 21; k++) tick();
        check("midop_busy", 64'(busy_o), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst_result", result_o, 64'd0);
        check("midrst_flags", {62'd0, ready_o, busy_o}, 64'd0);
        rst = 1'b0; start_i = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy_o), 64'd0);

        // Random operands against the reference model.
        for (int i = 0; i < 8; i++) begin
            logic         s;
            logic [W-1:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
            if (i % 3 == 0) b = ~b + 1;
            run_op(s, a, b, model(s, a, b), 1, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
